// File: rtl/wsram_arb_pkg.sv
// Shared types for the weight-SRAM read-port arbiter: FSM encoding and index sizing.
package wsram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_e;

  // Width needed to index n items; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wsram_rd_arb_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module rr_pick
  import wsram_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic         valid
);

  logic [W-1:0] idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wsram_rd_arb.sv
// Arbitrates NUM_REQ loaders onto one weight-SRAM read port and routes returns by owner tag.
module wsram_rd_arb
  import wsram_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int RAM_INDEX_WIDTH  = 16,
  parameter int RAM_DATA_WIDTH   = 512,
  parameter int RAM_READ_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  output logic [NUM_REQ-1:0]                  wgrant_o,
  input  logic [NUM_REQ-1:0]                  read_last_i,
  input  logic [NUM_REQ-1:0]                  ren_i,
  input  logic [NUM_REQ*RAM_INDEX_WIDTH-1:0]  rindex_i,
  output logic                                ram_ren_o,
  output logic [RAM_INDEX_WIDTH-1:0]          ram_rindex_o,
  input  logic [RAM_DATA_WIDTH-1:0]           ram_rdata_i,
  input  logic                                ram_rvalid_i,
  output logic [RAM_DATA_WIDTH-1:0]           rdata_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [idx_width(NUM_REQ)-1:0]       owner_o,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int OW = idx_width(NUM_REQ);
  localparam int CW = idx_width(RAM_READ_LATENCY + 2);
  localparam int QW = idx_width(RAM_READ_LATENCY + 1);
  localparam int L  = RAM_READ_LATENCY;

  arb_state_e           state, state_nxt;
  logic [OW-1:0]        owner, rr_ptr, pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_valid;
  logic [CW-1:0]        inflight, inflight_nxt;
  logic [L-1:0]         tag_vld;
  logic [OW-1:0]        tag_own [L];
  logic [QW-1:0]        quiet;
  logic                 in_grant, tag_hit, rvalid_accept, stray, ren_err;
  logic                 err_q;

  rr_pick #(.N(NUM_REQ), .W(OW)) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_onehot[i]) pick_idx = OW'(i);
  end

  // Outputs are forced quiet while rst is held, even though state clears only at the edge.
  assign in_grant      = (state == S_GRANT) && !rst;
  assign wgrant_o      = in_grant ? (NUM_REQ'(1) << owner) : '0;
  assign ram_ren_o     = in_grant && ren_i[owner];
  assign ram_rindex_o  = rindex_i[int'(owner)*RAM_INDEX_WIDTH +: RAM_INDEX_WIDTH];
  assign rdata_o       = ram_rdata_i;
  assign tag_hit       = tag_vld[L-1] && (inflight != '0);
  assign rvalid_accept = ram_rvalid_i && tag_hit && !rst;
  assign rvalid_o      = rvalid_accept ? (NUM_REQ'(1) << tag_own[L-1]) : '0;
  assign stray         = ram_rvalid_i && !tag_hit;
  assign ren_err       = |(ren_i & ~wgrant_o);
  assign owner_o       = owner;
  assign busy_o        = (state != S_IDLE) && !rst;
  assign err_o         = err_q && !rst;

  always_comb begin
    case ({ram_ren_o, rvalid_accept})
      2'b10:   inflight_nxt = inflight + CW'(1);
      2'b01:   inflight_nxt = inflight - CW'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable_i && pick_valid) state_nxt = S_GRANT;
      S_GRANT: if ((read_last_i[owner] && ren_i[owner]) || !req_i[owner]) state_nxt = S_DRAIN;
      S_DRAIN: if (inflight_nxt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      inflight <= '0;
      tag_vld  <= '0;
      quiet    <= QW'(L);
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (state == S_IDLE && state_nxt == S_GRANT) begin
        owner  <= pick_idx;
        rr_ptr <= (pick_idx == OW'(NUM_REQ - 1)) ? '0 : pick_idx + OW'(1);
      end
      tag_vld[0] <= ram_ren_o;
      for (int i = 1; i < L; i++) tag_vld[i] <= tag_vld[i-1];
      if (quiet != '0) quiet <= quiet - QW'(1);
      // Returns of reads abandoned by rst are expected for L cycles; don't flag them.
      if (ren_err || (stray && quiet == '0)) err_q <= 1'b1;
    end
  end

  // NOTE: tag owner payload has no reset; it is only ever consumed when tag_vld qualifies it.
  always_ff @(posedge clk) begin
    tag_own[0] <= owner;
    for (int i = 1; i < L; i++) tag_own[i] <= tag_own[i-1];
  end

endmodule

// File: tb/tb_wsram_rd_arb.sv
// Directed bench: per-cycle vector table plus requester/RAM-model sequences.
module tb_wsram_rd_arb;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int DW = 512;
  localparam int L  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable_i;
  logic [N-1:0]    req_i, wgrant_o, read_last_i, ren_i, rvalid_o;
  logic [N*IW-1:0] rindex_i;
  logic            ram_ren_o, ram_rvalid_i, busy_o, err_o;
  logic [IW-1:0]   ram_rindex_o;
  logic [DW-1:0]   ram_rdata_i, rdata_o;
  logic [1:0]      owner_o;

  always #5 clk = ~clk;

  wsram_rd_arb #(
    .NUM_REQ(N), .RAM_INDEX_WIDTH(IW), .RAM_DATA_WIDTH(DW), .RAM_READ_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .req_i(req_i), .wgrant_o(wgrant_o),
    .read_last_i(read_last_i), .ren_i(ren_i), .rindex_i(rindex_i),
    .ram_ren_o(ram_ren_o), .ram_rindex_o(ram_rindex_o), .ram_rdata_i(ram_rdata_i),
    .ram_rvalid_i(ram_rvalid_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, en;
    logic [3:0] req, ren, last;
    logic       rv;
    int         reps;
    logic [3:0] e_gnt;
    logic       e_ren;
    logic [3:0] e_rv;
    logic       e_busy, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic [3:0] req, input logic [3:0] ren,
                     input logic [3:0] last, input logic rv, input int reps, input logic [3:0] e_gnt,
                     input logic e_ren, input logic [3:0] e_rv, input logic e_busy, input logic e_err);
    vec_t v;
    v.rst = r; v.en = en; v.req = req; v.ren = ren; v.last = last; v.rv = rv; v.reps = reps;
    v.e_gnt = e_gnt; v.e_ren = e_ren; v.e_rv = e_rv; v.e_busy = e_busy; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic apply_row(input int idx, input vec_t r);
    for (int i = 0; i < r.reps; i++) begin
      @(posedge clk); #1;
      rst = r.rst; enable_i = r.en; req_i = r.req; ren_i = r.ren;
      read_last_i = r.last; ram_rvalid_i = r.rv;
      @(negedge clk);
      check($sformatf("row%0d.%0d wgrant", idx, i), 64'(wgrant_o), 64'(r.e_gnt));
      check($sformatf("row%0d.%0d ram_ren", idx, i), 64'(ram_ren_o), 64'(r.e_ren));
      check($sformatf("row%0d.%0d rvalid", idx, i), 64'(rvalid_o), 64'(r.e_rv));
      check($sformatf("row%0d.%0d busy", idx, i), 64'(busy_o), 64'(r.e_busy));
      check($sformatf("row%0d.%0d err", idx, i), 64'(err_o), 64'(r.e_err));
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; enable_i = 1'b0; req_i = '0; ren_i = '0; read_last_i = '0;
    ram_rvalid_i = 1'b0; rindex_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requester + RAM model state
  int         need[N];
  int         abort_at[N];
  int         exp_order[$];
  logic       pv[L];
  int         pown[L];
  logic [IW-1:0] pidx[L];

  task automatic run_model(input logic [3:0] mask, input int max_cyc, input string tag);
    int done[N];
    int rv_cnt[N];
    int tgt[N];
    int order[$];
    int cyc, tail, last_ren, s_own;
    logic s_ren, exp_ren, all_done;
    logic [IW-1:0] s_idx;
    logic [3:0] g, prev_g, exp_rv;
    cyc = 0; tail = -1; last_ren = -1; s_own = 0; s_ren = 1'b0; s_idx = '0; prev_g = '0;
    for (int k = 0; k < N; k++) begin
      done[k] = 0; rv_cnt[k] = 0;
      tgt[k] = (abort_at[k] != 0) ? abort_at[k] : need[k];
    end
    for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pown[i] = 0; pidx[i] = '0; end
    enable_i = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      for (int i = L - 1; i > 0; i--) begin
        pv[i] = pv[i-1]; pown[i] = pown[i-1]; pidx[i] = pidx[i-1];
      end
      pv[0] = s_ren; pown[0] = s_own; pidx[0] = s_idx;
      ram_rvalid_i = pv[L-1];
      ram_rdata_i  = {32{pidx[L-1]}};
      g = wgrant_o;
      for (int k = 0; k < N; k++) begin
        req_i[k]       = mask[k] && (done[k] < tgt[k]);
        ren_i[k]       = g[k] && req_i[k];
        read_last_i[k] = ren_i[k] && (abort_at[k] == 0) && (done[k] == need[k] - 1);
        rindex_i[k*IW +: IW] = IW'(k * 256 + done[k]);
      end
      if (g != '0 && g != prev_g) begin
        for (int k = 0; k < N; k++) if (g[k]) order.push_back(k);
        if (last_ren >= 0) check($sformatf("%s switch gap", tag), 64'(cyc - last_ren), 64'(L + 2));
      end
      prev_g = g;
      @(negedge clk);
      exp_ren = |ren_i;
      check($sformatf("%s c%0d ram_ren", tag, cyc), 64'(ram_ren_o), 64'(exp_ren));
      s_ren = exp_ren;
      if (exp_ren) begin
        for (int k = 0; k < N; k++) if (ren_i[k]) s_own = k;
        s_idx = IW'(s_own * 256 + done[s_own]);
        check($sformatf("%s c%0d rindex", tag, cyc), 64'(ram_rindex_o), 64'(s_idx));
        done[s_own]++;
        last_ren = cyc;
      end
      exp_rv = pv[L-1] ? 4'(1 << pown[L-1]) : 4'b0;
      check($sformatf("%s c%0d rvalid", tag, cyc), 64'(rvalid_o), 64'(exp_rv));
      if (pv[L-1]) check($sformatf("%s c%0d rdata", tag, cyc), rdata_o[63:0], {4{pidx[L-1]}});
      for (int k = 0; k < N; k++) if (rvalid_o[k]) rv_cnt[k]++;
      all_done = 1'b1;
      for (int k = 0; k < N; k++) if (mask[k] && done[k] < tgt[k]) all_done = 1'b0;
      if (all_done && tail < 0) tail = L + 4;
      if (tail >= 0) begin
        tail--;
        if (tail == 0) break;
      end
      cyc++;
      if (cyc > max_cyc) begin
        checks++; errors++;
        $display("FAIL %s timeout: %0d cycles without completion", tag, cyc);
        break;
      end
    end
    req_i = '0; ren_i = '0; read_last_i = '0; ram_rvalid_i = 1'b0;
    for (int k = 0; k < N; k++)
      check($sformatf("%s rvalid count %0d", tag, k), 64'(rv_cnt[k]), 64'(mask[k] ? tgt[k] : 0));
    check($sformatf("%s grant count", tag), 64'(order.size()), 64'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < order.size(); i++)
      check($sformatf("%s grant order %0d", tag, i), 64'(order[i]), 64'(exp_order[i]));
    check($sformatf("%s err", tag), 64'(err_o), 64'(0));
    check($sformatf("%s idle", tag), 64'(busy_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; req_i = '0; ren_i = '0; read_last_i = '0;
    rindex_i = '0; ram_rdata_i = '0; ram_rvalid_i = 1'b0;

    //  rst en req      ren      last     rv reps gnt      ren rv       busy err
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 10, 4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0100, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0100, 4'b0100, 4'b0000, 0, 1,  4'b0100, 1, 4'b0000, 1, 0);
    add(0, 0, 4'b0100, 4'b0100, 4'b0100, 0, 1,  4'b0100, 1, 4'b0000, 1, 0);
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 1, 0);
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, 1, 2,  4'b0000, 0, 4'b0100, 1, 0);
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0001, 4'b1001, 4'b0000, 0, 1,  4'b0001, 1, 4'b0000, 1, 0);
    add(0, 1, 4'b0001, 4'b1000, 4'b0000, 0, 1,  4'b0001, 0, 4'b0000, 1, 1);
    add(0, 1, 4'b0001, 4'b0001, 4'b0001, 0, 1,  4'b0001, 1, 4'b0000, 1, 1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1,  4'b0000, 0, 4'b0001, 1, 1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 1, 1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1,  4'b0000, 0, 4'b0001, 1, 1);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 1);
    add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 1);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0001, 4'b0001, 4'b0000, 0, 1,  4'b0001, 1, 4'b0000, 1, 0);
    add(1, 1, 4'b0001, 4'b0001, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1,  4'b0000, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1,  4'b0000, 0, 4'b0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

    // All four requesters, 16 reads each with read_last on the 16th.
    reset_dut();
    for (int k = 0; k < N; k++) begin need[k] = 16; abort_at[k] = 0; end
    exp_order = '{0, 1, 2, 3};
    run_model(4'b1111, 600, "all4");

    // Owner 1 aborts after 5 reads, then requester 2 is served.
    reset_dut();
    need     = '{0, 16, 4, 0};
    abort_at = '{0, 5, 0, 0};
    exp_order = '{1, 2};
    run_model(4'b0110, 300, "abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
